// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: a command-driven controller for a WIDTH-bit bank of
// JK flip-flops. Each accepted command becomes per-bit J/K drive patterns
// that are applied for one cycle, or for cmd_len cycles (COUNT/SHIFT).
// The applied J/K vectors are exported so the bank behaviour can be observed.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] j_dbg,
    output logic [WIDTH-1:0] k_dbg,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SET    = 3'd2,
        OP_TOGGLE = 3'd3,
        OP_LOAD   = 3'd4,
        OP_COUNT  = 3'd5,
        OP_SHIFT  = 3'd6,
        OP_RSVD   = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] remain;

    op_t              cmd_op_t;
    logic             accept;
    logic             multi_cycle;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic [WIDTH-1:0] q_next;

    assign cmd_op_t    = op_t'(cmd_op);
    // Ready only while idle and out of reset; goes high in the done cycle,
    // which is what lets a new command be taken back-to-back.
    assign cmd_ready   = rst & (state == S_IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign multi_cycle = (cmd_op_t == OP_COUNT) || (cmd_op_t == OP_SHIFT);

    assign q_bar = ~q;
    assign j_dbg = j_vec;
    assign k_dbg = k_vec;

    // Translate the latched command and current q into J/K drive vectors.
    always_comb begin : jk_decode
        logic carry;
        // NOTE: every always_comb output gets a default first, so no path
        // through the case statement can leave a value held (no latch).
        j_vec = '0;
        k_vec = '0;
        carry = 1'b1;
        if (state == S_EXEC) begin
            case (op_r)
                OP_CLEAR: begin
                    k_vec = '1;
                end
                OP_SET: begin
                    j_vec = '1;
                end
                OP_TOGGLE: begin
                    j_vec = data_r;
                    k_vec = data_r;
                end
                OP_LOAD: begin
                    j_vec = data_r;
                    k_vec = ~data_r;
                end
                OP_COUNT: begin
                    // Bit i toggles when all lower bits are 1 (ripple carry).
                    for (int i = 0; i < WIDTH; i++) begin
                        j_vec[i] = carry;
                        k_vec[i] = carry;
                        carry    = carry & q[i];
                    end
                end
                OP_SHIFT: begin
                    j_vec = {q[WIDTH-2:0], data_r[0]};
                    k_vec = ~{q[WIDTH-2:0], data_r[0]};
                end
                default: begin
                    // NOP and reserved opcode: bank holds.
                end
            endcase
        end
    end

    // Per-bit JK next state: hold, clear, set or toggle.
    assign q_next = (j_vec & ~q) | (~k_vec & q);

    // Sequencer FSM, JK bank register and registered status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_r   <= OP_NOP;
            data_r <= '0;
            remain <= '0;
            q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            q    <= q_next;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= cmd_op_t;
                        data_r <= cmd_data;
                        remain <= multi_cycle ? cmd_len : LEN_W'(1);
                        if (multi_cycle && (cmd_len == '0)) begin
                            // Zero-length COUNT/SHIFT: no EXEC cycle at all.
                            done <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    remain <= remain - LEN_W'(1);
                    if (remain == LEN_W'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= (op_r == OP_RSVD);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: directed scenarios followed by
// random command streams, compared against an arithmetic model of the bank.
module tb_jk_bank_sequencer;

    localparam int W = 4;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_data = '0;
    logic [L-1:0] cmd_len = '0;
    logic         cmd_ready;
    logic [W-1:0] q, q_bar, j_dbg, k_dbg;
    logic         busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int mq       = 0;   // model of the bank value

    jk_bank_sequencer #(.WIDTH(W), .LEN_W(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .q        (q),
        .q_bar    (q_bar),
        .j_dbg    (j_dbg),
        .k_dbg    (k_dbg),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of the bank after one cycle of the given operation.
    function automatic int model_next(input int op, input int data, input int qv);
        case (op)
            1:       return 0;
            2:       return 15;
            3:       return qv ^ data;
            4:       return data;
            5:       return (qv + 1) % 16;
            6:       return ((qv << 1) | (data & 1)) & 15;
            default: return qv;
        endcase
    endfunction

    // J/K vectors an operation must present for bank value qv.
    function automatic void model_jk(input int op, input int data, input int qv,
                                     output int j, output int k);
        case (op)
            1: begin j = 0;    k = 15;          end
            2: begin j = 15;   k = 0;           end
            3: begin j = data; k = data;        end
            4: begin j = data; k = ~data & 15;  end
            5: begin j = (qv ^ (qv + 1)) & 15; k = j; end
            6: begin j = ((qv << 1) | (data & 1)) & 15; k = ~j & 15; end
            default: begin j = 0; k = 0; end
        endcase
    endfunction

    // Called just after a negedge in an idle or done cycle; returns just after
    // the negedge of the done cycle with cmd_valid dropped.
    task automatic do_cmd(input int op, input int data, input int len);
        int n, ej, ek;
        check("pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = W'(data);
        cmd_len   = L'(len);
        @(negedge clk);
        n = (op == 5 || op == 6) ? len : 1;
        for (int c = 0; c < n; c++) begin
            model_jk(op, data, mq, ej, ek);
            check("exec_busy", busy, 1);
            check("exec_ready", cmd_ready, 0);
            check("exec_done", done, 0);
            check("exec_q", q, mq);
            check("exec_j", j_dbg, ej);
            check("exec_k", k_dbg, ek);
            mq = model_next(op, data, mq);
            // Operand changes while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = W'($urandom);
            cmd_len   = L'($urandom);
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("done_err", err, (op == 7) ? 1 : 0);
        check("done_busy", busy, 0);
        check("done_ready", cmd_ready, 1);
        check("done_q", q, mq);
        check("done_qbar", q_bar, ~mq & 15);
        check("done_j", j_dbg, 0);
        check("done_k", k_dbg, 0);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", cmd_ready, 1);
            check("idle_q", q, mq);
        end
    endtask

    initial begin
        int op, data, len;

        // 1: reset state, then idle with cmd_valid low.
        #1;
        check("rst_q", q, 0);
        check("rst_qbar", q_bar, 15);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_j", j_dbg, 0);
        check("rst_k", k_dbg, 0);
        @(negedge clk);
        rst = 1'b1;
        mq  = 0;
        idle(3);
        check("s1_qbar", q_bar, 15);

        // 2: LOAD then back-to-back TOGGLE.
        do_cmd(4, 4'b1010, 0);
        check("s2_load", q, 4'b1010);
        do_cmd(3, 4'b0110, 0);
        check("s2_toggle", q, 4'b1100);

        // 3: LOAD then COUNT len=5 through the wrap.
        do_cmd(4, 4'b1101, 0);
        do_cmd(5, 0, 5);
        check("s3_count", q, 4'b0010);

        // 4: SET, CLEAR, zero-length COUNT.
        do_cmd(2, 0, 0);
        check("s4_set", q, 4'b1111);
        do_cmd(1, 0, 0);
        check("s4_clear", q, 4'b0000);
        idle(1);
        do_cmd(5, 0, 0);
        check("s4_len0", q, 4'b0000);

        // 5: LOAD, SHIFT with serial-in 1, reserved opcode.
        do_cmd(4, 4'b0001, 0);
        do_cmd(6, 1, 3);
        check("s5_shift", q, 4'b1111);
        do_cmd(7, int'($urandom_range(0, 15)), 0);
        check("s5_rsvd", q, 4'b1111);

        // 6: reset in the middle of COUNT len=8.
        do_cmd(4, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = '0;
        cmd_len   = 4'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("s6_busy", busy, 1);
            check("s6_q", q, mq);
            mq = model_next(5, 0, mq);
            @(negedge clk);
        end
        check("s6_pre_q", q, 3);
        #2 rst = 1'b0;
        #1;
        mq = 0;
        check("s6_abort_q", q, 0);
        check("s6_abort_qbar", q_bar, 15);
        check("s6_abort_busy", busy, 0);
        check("s6_abort_done", done, 0);
        check("s6_abort_ready", cmd_ready, 0);
        @(negedge clk);
        check("s6_rst_done", done, 0);
        rst = 1'b1;
        idle(1);
        do_cmd(4, 4'b0101, 0);
        check("s6_load", q, 4'b0101);

        // Random command stream with random gaps.
        for (int t = 0; t < 80; t++) begin
            op   = int'($urandom_range(0, 7));
            data = int'($urandom_range(0, 15));
            len  = int'($urandom_range(0, 7));
            do_cmd(op, data, len);
            idle(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
